// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types and constants for the PPU VRAM host writer
//
// Purpose: region codes, per-region word depths, the write-queue entry type and
// helpers for range checking and write-enable decoding.
// Ports: none (package).
// Optional feature macro used by importers: PPU_VRAM_WR_DIRECT_PAL_EN.

package ppu_pkg;

  typedef enum logic [2:0] {
    TILE_BUF = 3'd0,
    TILE_GFX = 3'd1,
    SPR_GFX  = 3'd2,
    PAL      = 3'd3,
    OAM      = 3'd4,
    STATUS   = 3'd7
  } region_e;

  localparam int TILE_BUF_DEPTH = 512;
  localparam int TILE_GFX_DEPTH = 2048;
  localparam int SPR_GFX_DEPTH  = 2048;
  localparam int PAL_DEPTH      = 8;
  localparam int OAM_DEPTH      = 256;

  typedef struct packed {
    region_e     region;
    logic [10:0] offset;
    logic [31:0] data;
  } fifo_entry_t;

  // True only for a writable memory region with the offset inside that memory.
  // Offsets are widened to 12 bits so the 2048-word limits compare correctly.
  function automatic logic offset_ok(logic [2:0] region, logic [10:0] offset);
    logic [11:0] off12;
    off12 = {1'b0, offset};
    case (region)
      TILE_BUF: return off12 < 12'(TILE_BUF_DEPTH);
      TILE_GFX: return off12 < 12'(TILE_GFX_DEPTH);
      SPR_GFX:  return off12 < 12'(SPR_GFX_DEPTH);
      PAL:      return off12 < 12'(PAL_DEPTH);
      OAM:      return off12 < 12'(OAM_DEPTH);
      default:  return 1'b0;
    endcase
  endfunction

  // One-hot memory write enable for a region code 0..4.
  function automatic logic [4:0] region_we(region_e region);
    return 5'(1) << region;
  endfunction

endpackage

// File: rtl/ppu_wr_fifo.sv
// rtl/ppu_wr_fifo.sv - synchronous write-queue FIFO with level output
//
// Purpose: in-order queue of entries of any packed type; DEPTH must be a power
// of two (>= 2). Pointers carry one extra wrap bit to tell full from empty.
// Ports:
//   clk, reset          clock, synchronous active-high reset (flushes queue)
//   push, push_data     enqueue request and entry (ignored when full)
//   pop, pop_data       dequeue request (ignored when empty); head entry
//   full, empty, level  occupancy status

module ppu_wr_fifo #(
  parameter type entry_t = logic [7:0],
  parameter int  DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty    = (wr_ptr == rd_ptr);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ppu_vram_writer.sv
// rtl/ppu_vram_writer.sv - Avalon host writer queueing VRAM updates for vblank
//
// Purpose: decodes host writes by region, range-checks them, queues them and
// drains the queue into the PPU memories one word per cycle while vblank is high.
// Out-of-range and invalid-region writes are dropped and counted (saturating).
// Optional macro PPU_VRAM_WR_DIRECT_PAL_EN: palette writes bypass the queue and
// are written on the next cycle regardless of vblank.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   chipselect, write, read         Avalon slave strobes
//   address[13:11] / [10:0]         region code / word offset
//   writedata, readdata             host write word / registered status word
//   waitrequest                     write cannot be accepted this cycle
//   vblank                          drain enable
//   we, wr_addr, wr_data            registered memory write port (we one-hot)
//   fifo_level                      current queue occupancy

module ppu_vram_writer
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 14,
  parameter int DROP_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic                        read,
  input  logic [ADDR_W-1:0]           address,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        waitrequest,
  input  logic                        vblank,
  output logic [4:0]                  we,
  output logic [10:0]                 wr_addr,
  output logic [31:0]                 wr_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  logic [2:0]        region;
  logic [10:0]       offset;
  logic              in_range;
  logic              accept;
  logic              bypass_region;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop_evt;
  logic              status_rd;
  logic [31:0]       status_word;
  logic [DROP_W-1:0] drop_cnt;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;

  assign region   = address[13:11];
  assign offset   = address[10:0];
  assign in_range = offset_ok(region, offset);

`ifdef PPU_VRAM_WR_DIRECT_PAL_EN
  assign bypass_region = (region == PAL);
`else
  assign bypass_region = 1'b0;
`endif

  // Palette writes never wait when they bypass the queue.
  assign waitrequest = chipselect & write & fifo_full & ~bypass_region;
  assign accept      = chipselect & write & ~waitrequest;
  assign bypass      = accept & in_range & bypass_region;
  assign fifo_push   = accept & in_range & ~bypass_region;
  assign drop_evt    = accept & ~in_range & (region != STATUS);
  // A bypass owns the write port this cycle, so the queue head waits one cycle.
  assign fifo_pop    = vblank & ~fifo_empty & ~bypass;

  assign push_entry.region = region_e'(region);
  assign push_entry.offset = offset;
  assign push_entry.data   = writedata;

  assign status_rd   = chipselect & read & (region == STATUS);
  assign status_word = {8'(drop_cnt), vblank, fifo_full, fifo_empty, 21'(fifo_level)};

  ppu_wr_fifo #(
    .entry_t (fifo_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      we       <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      readdata <= '0;
      drop_cnt <= '0;
    end else begin
      readdata <= status_rd ? status_word : 32'd0;
      if (drop_evt && !(&drop_cnt)) drop_cnt <= drop_cnt + DROP_W'(1);
      if (bypass) begin
        we      <= region_we(PAL);
        wr_addr <= offset;
        wr_data <= writedata;
      end else if (fifo_pop) begin
        we      <= region_we(head.region);
        wr_addr <= head.offset;
        wr_data <= head.data;
      end else begin
        we      <= '0;
      end
    end
  end

endmodule

// File: doc/ppu_vram_writer.md
Name: ppu_vram_writer

Overview:
Host-side writer for the PPU video memories: tile buffer, tile graphics, sprite graphics, color palettes and OAM. It sits between the Avalon-MM slave interface and the memory write ports. Host writes are decoded by region, range-checked and queued in a FIFO. The queue drains into the target memory one word per cycle, only while vblank is high, so the PPU fetch engine never sees a mid-frame update. The top level muxes memory address and write-enable between this block (vblank) and the PPU fetch engine (active video).

Parameters:
FIFO_DEPTH, 16, write-queue entries; power of two, minimum 2
ADDR_W, 14, host word-address width
DROP_W, 8, width of the saturating dropped-write counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe, status register only
address  in  ADDR_W  [13:11] region, [10:0] word offset
writedata  in  32  host write word
readdata  out  32  status word
waitrequest  out  1  high when a write cannot be accepted this cycle
vblank  in  1  drain enable, from the VGA timing block
we  out  5  one-hot write enable: bit0 tile_buffer, bit1 tile_graphics, bit2 sprite_graphics, bit3 color_palettes, bit4 OAM
wr_addr  out  11  word address; each memory uses its low bits
wr_data  out  32  write word; palette memory uses [23:0]
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values: we=0, wr_addr=0, wr_data=0, readdata=0, waitrequest=0, FIFO empty, fifo_level=0, drop counter=0.
- Reset mid-drain: FIFO flushed and we cleared on the next edge; queued writes are lost.
- Region limits, by region code (value in the [13:11] field of address):
  - 0 tile_buffer: offset < 512
  - 1 tile_graphics: offset < 2048
  - 2 sprite_graphics: offset < 2048
  - 3 color_palettes: offset < 8
  - 4 OAM: offset < 256
  - 5, 6: invalid
  - 7: status; writes ignored
- Accept: chipselect & write & ~waitrequest.
  - Valid region and offset in range: push {region, offset, writedata}.
  - Otherwise: drop the write and increment the drop counter, saturating at all-ones.
  - Region-7 writes are ignored without counting.
- waitrequest = chipselect & write & fifo_full; combinational. Host holds its signals until waitrequest is low.
- Drain: when vblank & ~empty, pop the head entry. The next cycle drives we=onehot(region), wr_addr=offset, wr_data=data, all registered. we is high for exactly one cycle per popped entry; otherwise we=0. wr_addr and wr_data hold their last values.
- Drain rate: one entry per cycle, in order, with no reordering or merging.
- A pop on the last vblank cycle still lands one cycle after vblank falls. This is accepted: the PPU's first fetch is more than 1 cycle after vblank deasserts.
- Simultaneous push and pop: level unchanged. A push into a full FIFO is blocked by waitrequest; pop with a new write in the same cycle is allowed, the push lands the next cycle.
- Status read (chipselect & read, region 7): readdata registered, valid 1 cycle after the read. Fields:
  - [31:24] drop counter
  - [23] vblank
  - [22] full
  - [21] empty
  - [20:0] zero-extended fifo_level
- Reads of other regions return 0.
- Pointer wrap: read and write pointers are one bit wider than log2(FIFO_DEPTH).
  - full: pointers equal in index bits, MSB differs.
  - empty: pointers fully equal.

Optional Feature:
PPU_VRAM_WR_DIRECT_PAL_EN:
- Defined: region-3 writes bypass the FIFO and are written next cycle regardless of vblank, for mid-frame palette effects.
  - Bypass takes priority over a FIFO pop in the same cycle; that pop is delayed one cycle.
  - A palette write does not assert waitrequest even when the FIFO is full.
- Not defined: palette writes are queued like every other region.

Decomposition:
- Package ppu_pkg holds:
  - the region_e enum (TILE_BUF=0, TILE_GFX, SPR_GFX, PAL, OAM, STATUS=7);
  - per-region depth constants (512, 2048, 2048, 8, 256);
  - the fifo_entry_t struct {region_e region; logic[10:0] offset; logic[31:0] data}.
- Sub-module ppu_wr_fifo: synchronous FIFO parameterized by entry type and depth, with push, pop, full, empty and level.

Test Plan:
- Idle vblank=0; write tile_graphics off 0x010 data 0xDEADBEEF -> fifo_level=1, we=0. Raise vblank -> next-next cycle we=5'b00010, wr_addr=0x010, wr_data=0xDEADBEEF for 1 cycle, level=0.
- vblank=0; 16 writes then a 17th -> waitrequest high on the 17th. Raise vblank -> 17th accepted the cycle after the first pop; all 17 drained in order on consecutive cycles.
- Write palette off 8, OAM off 256, region 5 -> no push; status read gives [31:24]=3, empty=1.
- 300 invalid writes -> drop counter saturates at 0xFF.
- 4 writes queued, vblank high for 2 cycles -> exactly 2 writes, level=2. The rest drain on the next vblank.
- Assert reset with 3 entries queued during vblank -> we=0 next cycle, level=0, no further writes. With PPU_VRAM_WR_DIRECT_PAL_EN defined, a palette write during vblank=0 -> we=5'b01000 next cycle.
